// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath (master) drives the hazard inputs and consumes the keep/clear controls.
interface hazard_ctrl_if;
  logic [3:0] id_reg_a;
  logic [3:0] id_reg_b;
  logic       id_use_a;
  logic       id_use_b;
  logic       ex_mem_read;
  logic [3:0] ex_wreg;
  logic       id_branch_taken;
  logic       mem_instr_access;
  logic       mem_busy;
  logic       pc_keep;
  logic       if_keep;
  logic       idex_keep;
  logic       if_clear;
  logic       idex_clear;
  logic [7:0] stall_cnt;
  logic [1:0] state_dbg;

  modport master (
    output id_reg_a, id_reg_b, id_use_a, id_use_b, ex_mem_read, ex_wreg,
           id_branch_taken, mem_instr_access, mem_busy,
    input  pc_keep, if_keep, idex_keep, if_clear, idex_clear, stall_cnt, state_dbg
  );

  modport slave (
    input  id_reg_a, id_reg_b, id_use_a, id_use_b, ex_mem_read, ex_wreg,
           id_branch_taken, mem_instr_access, mem_busy,
    output pc_keep, if_keep, idex_keep, if_clear, idex_clear, stall_cnt, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, fetch/MEM structural conflicts,
// taken-branch flushes and external memory freezes, with a saturating stall counter.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_stall_cnt;
  logic [1:0] w_next_state;
  logic       w_lu_hazard;
  logic       w_pc_keep;
  logic       w_if_keep;
  logic       w_idex_keep;
  logic       w_if_clear;
  logic       w_idex_clear;

  // The bubble just inserted by STALL must not re-trigger the same load-use hazard.
  always_comb begin
    w_lu_hazard = 1'b0;
    if (r_state != ST_STALL) begin
      w_lu_hazard = bus.ex_mem_read &
                    ((bus.id_use_a & (bus.id_reg_a == bus.ex_wreg)) |
                     (bus.id_use_b & (bus.id_reg_b == bus.ex_wreg)));
    end
  end

  always_comb begin
    w_pc_keep    = 1'b0;
    w_if_keep    = 1'b0;
    w_idex_keep  = 1'b0;
    w_if_clear   = 1'b0;
    w_idex_clear = 1'b0;
    w_next_state = ST_RUN;
    if (!rst) begin
      w_if_clear   = 1'b1;
      w_idex_clear = 1'b1;
    end else if (bus.mem_busy) begin
      w_pc_keep    = 1'b1;
      w_if_keep    = 1'b1;
      w_idex_keep  = 1'b1;
      w_next_state = ST_WAIT;
    end else if (w_lu_hazard) begin
      w_pc_keep    = 1'b1;
      w_if_keep    = 1'b1;
      w_idex_clear = 1'b1;
      w_next_state = ST_STALL;
    end else if (bus.mem_instr_access) begin
      // A taken branch must still load its target even though the fetch slot is lost.
      w_pc_keep    = ~bus.id_branch_taken;
      w_if_clear   = 1'b1;
    end else if (bus.id_branch_taken) begin
      w_if_clear   = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (w_pc_keep && (r_stall_cnt != 8'hFF)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
    end
  end

  assign bus.pc_keep    = w_pc_keep;
  assign bus.if_keep    = w_if_keep;
  assign bus.idex_keep  = w_idex_keep;
  assign bus.if_clear   = w_if_clear;
  assign bus.idex_clear = w_idex_clear;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       pc_keep;
    logic       if_keep;
    logic       idex_keep;
    logic       if_clear;
    logic       idex_clear;
    logic [7:0] stall_cnt;
    logic [1:0] state;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   modelMode = 0;
  int   modelCnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of inputs on the rising edge (DUT acts on the falling edge),
  // predicts the response from the rules and advances the model past the next edge.
  task automatic applyStimulus(input logic r, input logic [3:0] ra, input logic ua,
                               input logic [3:0] rb, input logic ub, input logic emr,
                               input logic [3:0] wr, input logic br, input logic mia,
                               input logic busy);
    exp_t e;
    bit   hazard;
    int   nextMode;
    @(posedge clk);
    rst                  = r;
    bus.id_reg_a         = ra;
    bus.id_use_a         = ua;
    bus.id_reg_b         = rb;
    bus.id_use_b         = ub;
    bus.ex_mem_read      = emr;
    bus.ex_wreg          = wr;
    bus.id_branch_taken  = br;
    bus.mem_instr_access = mia;
    bus.mem_busy         = busy;
    e = '0;
    nextMode = 0;
    if (!r) begin
      modelMode = 0;
      modelCnt  = 0;
      e.if_clear   = 1'b1;
      e.idex_clear = 1'b1;
    end else begin
      hazard = emr && (modelMode != 1) &&
               ((ua && ra == wr) || (ub && rb == wr));
      if (busy) begin
        e.pc_keep = 1'b1; e.if_keep = 1'b1; e.idex_keep = 1'b1;
        nextMode = 2;
      end else if (hazard) begin
        e.pc_keep = 1'b1; e.if_keep = 1'b1; e.idex_clear = 1'b1;
        nextMode = 1;
      end else if (mia) begin
        e.pc_keep  = !br;
        e.if_clear = 1'b1;
      end else if (br) begin
        e.if_clear = 1'b1;
      end
    end
    e.state     = modelMode[1:0];
    e.stall_cnt = modelCnt[7:0];
    expQ.push_back(e);
    if (r) begin
      modelMode = nextMode;
      if (e.pc_keep && modelCnt < 255) modelCnt = modelCnt + 1;
    end
  endtask

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("pc_keep",    {7'd0, bus.pc_keep},    {7'd0, e.pc_keep});
    checkField("if_keep",    {7'd0, bus.if_keep},    {7'd0, e.if_keep});
    checkField("idex_keep",  {7'd0, bus.idex_keep},  {7'd0, e.idex_keep});
    checkField("if_clear",   {7'd0, bus.if_clear},   {7'd0, e.if_clear});
    checkField("idex_clear", {7'd0, bus.idex_clear}, {7'd0, e.idex_clear});
    checkField("stall_cnt",  bus.stall_cnt,          e.stall_cnt);
    checkField("state_dbg",  {6'd0, bus.state_dbg},  {6'd0, e.state});
  endtask

  // Monitor samples the Mealy outputs mid-way between input change and the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadUse(input logic busy);
    applyStimulus(1, 3, 1, 0, 0, 1, 3, 0, 0, busy);
  endtask

  initial begin
    rst = 1'b0;
    bus.id_reg_a = '0; bus.id_reg_b = '0; bus.id_use_a = 0; bus.id_use_b = 0;
    bus.ex_mem_read = 0; bus.ex_wreg = '0; bus.id_branch_taken = 0;
    bus.mem_instr_access = 0; bus.mem_busy = 0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    loadUse(0);
    loadUse(0);
    idle();

    applyStimulus(1, 3, 0, 3, 0, 1, 3, 0, 0, 0);
    applyStimulus(1, 5, 0, 3, 1, 1, 3, 0, 0, 0);
    applyStimulus(1, 5, 0, 3, 1, 1, 3, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();

    repeat (3) loadUse(1);
    loadUse(0);
    loadUse(0);
    idle();

    repeat (300) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    loadUse(0);
    applyStimulus(0, 3, 1, 0, 0, 1, 3, 0, 0, 0);
    idle();
    idle();

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(posedge clk);
    #4;
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, pipeline clock; all state updates on falling edge, matching the pipeline registers.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports id_reg_a / id_reg_b, input, 4 each, source register indices of the instruction in ID.
REQ-004 SHALL have ports id_use_a / id_use_b, input, 1 each, high when the matching id_reg_x is actually read.
REQ-005 SHALL have port ex_mem_read, input, 1, instruction in EX is a load.
REQ-006 SHALL have port ex_wreg, input, 4, destination index of the instruction in EX.
REQ-007 SHALL have port id_branch_taken, input, 1, branch or jump in ID resolved taken this cycle.
REQ-008 SHALL have port mem_instr_access, input, 1, MEM stage uses the instruction memory this cycle (structural conflict with fetch).
REQ-009 SHALL have port mem_busy, input, 1, external memory or UART wait request.
REQ-010 SHALL have ports pc_keep, if_keep, idex_keep, output, 1 each, hold PC / IF-ID / ID-EX registers.
REQ-011 SHALL have ports if_clear, idex_clear, output, 1 each, load NOP (0x0800) / bubble into IF-ID / ID-EX.
REQ-012 SHALL have port stall_cnt, output, 8, saturating count of pc_keep cycles.
REQ-013 SHALL have port state_dbg, output, 2, current FSM state for LED display.

Function
REQ-014 SHALL implement FSM states RUN=0, STALL=1, WAIT=2; encoding 3 unused, recovers to RUN next edge.
REQ-015 SHALL drive all control outputs combinationally (Mealy) from current inputs and registered state.
REQ-016 SHALL define lu_hazard = ex_mem_read & ((id_use_a & id_reg_a==ex_wreg) | (id_use_b & id_reg_b==ex_wreg)), evaluated only when state != STALL.
REQ-017 SHALL apply priority per cycle: mem_busy > lu_hazard > mem_instr_access > id_branch_taken > none.
REQ-018 SHALL, on mem_busy=1: pc_keep=if_keep=idex_keep=1, both clears 0, next state WAIT.
REQ-019 SHALL, on lu_hazard (no mem_busy): pc_keep=if_keep=1, idex_clear=1, idex_keep=0, if_clear=0, next state STALL; branch and structural requests ignored that cycle.
REQ-020 SHALL, on mem_instr_access alone: pc_keep=1, if_clear=1 (lost fetch replaced by NOP), next state RUN.
REQ-021 SHALL, on mem_instr_access with id_branch_taken: pc_keep=0 so the branch target loads, if_clear=1, next state RUN.
REQ-022 SHALL, on id_branch_taken alone: if_clear=1, all keeps 0, next state RUN.
REQ-023 SHALL, with no condition: all outputs 0, next state RUN.
REQ-024 SHALL leave STALL after exactly one cycle (load-use bubble length 1) unless mem_busy forces WAIT.
REQ-025 SHALL return WAIT->RUN on the first cycle with mem_busy=0, evaluating hazards normally in that cycle.
REQ-026 SHALL never assert a keep and the clear of the same register together.
REQ-027 SHALL increment stall_cnt on each edge where pc_keep=1, saturating at 255 without wrap.

Reset
REQ-028 SHALL, while rst=0, force state=RUN, stall_cnt=0, all keeps 0, if_clear=1, idex_clear=1.
REQ-029 SHALL, on rst release mid-stall or mid-wait, resume from RUN with no residual stall or bubble.

Verification
REQ-030 SHALL test load-use: ex_mem_read=1, ex_wreg=3, id_use_a=1, id_reg_a=3 -> pc_keep=if_keep=idex_clear=1 one cycle, state STALL then RUN, stall_cnt=1.
REQ-031 SHALL test no false hazard: same as REQ-030 with id_use_a=0, id_use_b=0 -> all outputs 0, stall_cnt unchanged.
REQ-032 SHALL test structural conflict with branch: mem_instr_access=1, id_branch_taken=1 -> if_clear=1, pc_keep=0; mem_instr_access alone -> pc_keep=1, if_clear=1.
REQ-033 SHALL test freeze: mem_busy=1 for 3 cycles during a load-use -> keeps all 1, clears 0, state WAIT, stall_cnt +3; then hazard re-detected on release.
REQ-034 SHALL test saturation: 300 consecutive mem_busy cycles -> stall_cnt=255.
REQ-035 SHALL test async reset: rst=0 asserted mid-STALL without a clock edge -> state_dbg=0, stall_cnt=0, if_clear=idex_clear=1 immediately.
